// File: rtl/thunderbird.sv
// Ford Thunderbird tail-light sequencer: Moore FSM stepping three lamps per side.
// Optional hazard flash on simultaneous left+right is built when THUNDERBIRD_HAZARD_EN is defined.
module thunderbird #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  output logic [5:0] light_out
);

  localparam int unsigned    CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] L1   = 3'd1;
  localparam logic [2:0] L2   = 3'd2;
  localparam logic [2:0] L3   = 3'd3;
  localparam logic [2:0] R1   = 3'd4;
  localparam logic [2:0] R2   = 3'd5;
  localparam logic [2:0] R3   = 3'd6;
`ifdef THUNDERBIRD_HAZARD_EN
  localparam logic [2:0] LR3  = 3'd7;
`endif

  logic [CNT_W-1:0] cnt;
  logic             step;
  logic [2:0]       state;
  logic [2:0]       state_nxt;

  function automatic logic [5:0] decode(input logic [2:0] s);
    logic [5:0] d;
    d = '0;
    case (s)
      L1:  d = 6'b001000;
      L2:  d = 6'b011000;
      L3:  d = 6'b111000;
      R1:  d = 6'b000100;
      R2:  d = 6'b000110;
      R3:  d = 6'b000111;
`ifdef THUNDERBIRD_HAZARD_EN
      LR3: d = 6'b111111;
`endif
      default: d = '0;
    endcase
    return d;
  endfunction

  assign step = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sequences run to completion; requests are only looked at from IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
`ifdef THUNDERBIRD_HAZARD_EN
        if (left && right) state_nxt = LR3;
        else if (left)     state_nxt = L1;
        else if (right)    state_nxt = R1;
        else               state_nxt = IDLE;
`else
        if (left)          state_nxt = L1;
        else if (right)    state_nxt = R1;
        else               state_nxt = IDLE;
`endif
      end
      L1:      state_nxt = L2;
      L2:      state_nxt = L3;
      R1:      state_nxt = R2;
      R2:      state_nxt = R3;
      default: state_nxt = IDLE;
    endcase
  end

  // Lamps are registered alongside the state so they always equal decode(state).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      light_out <= '0;
    end else if (step) begin
      state     <= state_nxt;
      light_out <= decode(state_nxt);
    end
  end

endmodule

// File: tb/tb_thunderbird.sv
// Directed self-checking bench for thunderbird (default TICK_DIV plus a TICK_DIV=3 instance).
module tb_thunderbird;

  logic       clk;
  logic       reset;
  logic       left;
  logic       right;
  logic [5:0] light_out;
  logic       left3;
  logic       right3;
  logic [5:0] light3;

  int unsigned checks;
  int unsigned errors;

  thunderbird dut (
    .clk       (clk),
    .reset     (reset),
    .left      (left),
    .right     (right),
    .light_out (light_out)
  );

  thunderbird #(.TICK_DIV(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .left      (left3),
    .right     (right3),
    .light_out (light3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    left  = 1'b1;
    right = 1'b0;
    #2;
    checks++;
    if (light_out !== 6'b000000) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", light_out, 6'b000000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (light_out !== 6'b000000) begin
        errors++;
        $display("FAIL reset_hold[%0d] got=%b exp=%b", i, light_out, 6'b000000);
      end
    end
    left  = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (light_out !== 6'b000000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", light_out, 6'b000000);
    end
  endtask

  task automatic test_left_held;
    logic [5:0] exp [8];
    exp = '{6'b001000, 6'b011000, 6'b111000, 6'b000000,
            6'b001000, 6'b011000, 6'b111000, 6'b000000};
    left  = 1'b1;
    right = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (light_out !== exp[i]) begin
        errors++;
        $display("FAIL left_held[%0d] got=%b exp=%b", i, light_out, exp[i]);
      end
    end
    left = 1'b0;
  endtask

  task automatic test_right_held;
    logic [5:0] exp [4];
    exp = '{6'b000100, 6'b000110, 6'b000111, 6'b000000};
    right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (light_out !== exp[i]) begin
        errors++;
        $display("FAIL right_held[%0d] got=%b exp=%b", i, light_out, exp[i]);
      end
    end
    right = 1'b0;
  endtask

  task automatic test_no_abort;
    logic [5:0] exp [8];
    exp = '{6'b001000, 6'b011000, 6'b111000, 6'b000000,
            6'b000100, 6'b000110, 6'b000111, 6'b000000};
    left  = 1'b1;
    right = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        left  = 1'b0;
        right = 1'b1;
      end
      if (i == 4) right = 1'b0;
      checks++;
      if (light_out !== exp[i]) begin
        errors++;
        $display("FAIL no_abort[%0d] got=%b exp=%b", i, light_out, exp[i]);
      end
    end
  endtask

  task automatic test_both;
    logic [5:0] exp [4];
`ifdef THUNDERBIRD_HAZARD_EN
    exp = '{6'b111111, 6'b000000, 6'b111111, 6'b000000};
`else
    exp = '{6'b001000, 6'b011000, 6'b111000, 6'b000000};
`endif
    left  = 1'b1;
    right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (light_out !== exp[i]) begin
        errors++;
        $display("FAIL both[%0d] got=%b exp=%b", i, light_out, exp[i]);
      end
    end
    left  = 1'b0;
    right = 1'b0;
  endtask

  task automatic test_reset_mid;
    left = 1'b1;
    tick();
    tick();
    checks++;
    if (light_out !== 6'b011000) begin
      errors++;
      $display("FAIL mid_at_l2 got=%b exp=%b", light_out, 6'b011000);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (light_out !== 6'b000000) begin
      errors++;
      $display("FAIL mid_async_clear got=%b exp=%b", light_out, 6'b000000);
    end
    tick();
    checks++;
    if (light_out !== 6'b000000) begin
      errors++;
      $display("FAIL mid_held got=%b exp=%b", light_out, 6'b000000);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (light_out !== 6'b001000) begin
      errors++;
      $display("FAIL mid_restart got=%b exp=%b", light_out, 6'b001000);
    end
    left = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (light_out !== 6'b000000) begin
      errors++;
      $display("FAIL mid_complete got=%b exp=%b", light_out, 6'b000000);
    end
  endtask

  task automatic test_tick_div;
    logic [5:0] exp [7];
    exp = '{6'b000000, 6'b000000, 6'b001000, 6'b001000,
            6'b001000, 6'b011000, 6'b011000};
    reset = 1'b0;
    #2;
    reset  = 1'b1;
    left3  = 1'b1;
    right3 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 2) left3 = 1'b0;
      checks++;
      if (light3 !== exp[i]) begin
        errors++;
        $display("FAIL tick_div3[%0d] got=%b exp=%b", i, light3, exp[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    left   = 1'b0;
    right  = 1'b0;
    left3  = 1'b0;
    right3 = 1'b0;
    reset  = 1'b0;
    test_reset();
    test_left_held();
    test_right_held();
    test_no_abort();
    test_both();
    test_reset_mid();
    test_tick_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
